// File: rtl/mem_pkg.sv
// Shared encodings for the data memory bank: access sizes and FSM states.
package mem_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Request sequencing states: accept, touch the array, answer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and shifted store data for
// writes, right-shifted and sign/zero-extended data for loads.
// Assumes DATA_W >= 32 so byte and half extensions are non-empty.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int LANE_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [1:0]        size,
  input  logic [LANE_W-1:0] lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata_al,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] rd_shift;
  logic              fill_b;
  logic              fill_h;

  assign rd_shift = rword >> {lane, 3'b000};
  assign fill_b   = ~is_unsigned & rd_shift[7];
  assign fill_h   = ~is_unsigned & rd_shift[15];

  // Decode size into lane enables, place store data, extend load data.
  always_comb begin
    be        = '0;
    wdata_al  = wdata << {lane, 3'b000};
    rdata_ext = '0;
    case (size)
      SZ_BYTE: begin
        be        = NB'(1) << lane;
        rdata_ext = {{(DATA_W-8){fill_b}}, rd_shift[7:0]};
      end
      SZ_HALF: begin
        be        = NB'(3) << lane;
        rdata_ext = {{(DATA_W-16){fill_h}}, rd_shift[15:0]};
      end
      SZ_WORD: begin
        be        = '1;
        rdata_ext = rd_shift;
      end
      default: begin
        be        = '0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bank.sv
// Single-port data memory bank with byte/half/word loads and stores.
// Each request takes IDLE -> ACCESS -> RESP, one request per 3 cycles.
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE and the requester keeps
// req_valid and all req_* fields stable until that edge. The response has no
// back-pressure: rsp_valid is a single-cycle pulse, and rsp_rdata/rsp_err
// are 0 whenever rsp_valid is 0.
module data_mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output state_t            dbg_state
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int HI_LSB = IDX_W + LANE_W;

  state_t state_q, state_d;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;

  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;
  logic              err;
  logic              accept;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_al;
  logic [DATA_W-1:0] rdata_ext;

  assign idx       = r_addr[HI_LSB-1:LANE_W];
  assign lane      = r_addr[LANE_W-1:0];
  assign accept    = req_valid && req_ready;
  assign dbg_state = state_q;

  // State register; reset returns to IDLE and aborts any pending access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/response outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request fields on acceptance; they stay stable until RESP ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Error when misaligned, reserved size, or address beyond the array.
  always_comb begin
    err = 1'b0;
    case (r_size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = r_addr[0];
      SZ_WORD: err = (lane != '0);
      default: err = 1'b1;
    endcase
    if (r_addr[ADDR_W-1:HI_LSB] != '0) err = 1'b1;
  end

  mem_lane_align #(
    .DATA_W (DATA_W),
    .NB     (NB),
    .LANE_W (LANE_W)
  ) u_align (
    .size        (r_size),
    .lane        (lane),
    .is_unsigned (r_uns),
    .wdata       (r_wdata),
    .rword       (rd_word),
    .be          (be),
    .wdata_al    (wdata_al),
    .rdata_ext   (rdata_ext)
  );

  // Array access in ACCESS: lane-masked store (suppressed on error) and word read.
  always_ff @(posedge clk) begin
    if (state_q == ST_ACCESS) begin
      if (r_we && !err) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem[idx][b*8 +: 8] <= wdata_al[b*8 +: 8];
        end
      end
      rd_word <= mem[idx];
    end
  end

  // Response data is only visible during the RESP pulse and only for good loads.
  always_comb begin
    rsp_err   = rsp_valid & err;
    rsp_rdata = '0;
    if (rsp_valid && !err && !r_we) rsp_rdata = rdata_ext;
  end

endmodule
